// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: state and frame-result
// encodings, strobe constants and small row-decode helpers.
package keypad_pkg;

    localparam int         KEY_W         = 4;
    localparam logic [3:0] COL_IDLE_MASK = 4'hF;
    localparam logic [3:0] COL0_STROBE   = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } kp_state_e;

    typedef enum logic [1:0] {
        FR_NONE   = 2'd0,
        FR_SINGLE = 2'd1,
        FR_MULTI  = 2'd2
    } frame_res_e;

    function automatic logic [2:0] count_low(input logic [3:0] low_bits);
        count_low = {2'b00, low_bits[0]} + {2'b00, low_bits[1]}
                  + {2'b00, low_bits[2]} + {2'b00, low_bits[3]};
    endfunction

    // Lowest pressed row; only meaningful when exactly one bit is set.
    function automatic logic [1:0] low_row_index(input logic [3:0] low_bits);
        if (low_bits[0])      low_row_index = 2'd0;
        else if (low_bits[1]) low_row_index = 2'd1;
        else if (low_bits[2]) low_row_index = 2'd2;
        else                  low_row_index = 2'd3;
    endfunction

endpackage

// File: rtl/keypad_col_scanner.sv
// Column strobe rotation, row synchronizer and per-frame classification of the
// sampled rows into NONE / SINGLE(code) / MULTI.
module keypad_col_scanner
    import keypad_pkg::*;
#(
    parameter int CYCLES_PER_COL = 50_000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       rows_i,
    output logic [3:0]       cols_o,
    output logic             frame_done_o,
    output frame_res_e       frame_result_o,
    output logic [KEY_W-1:0] frame_code_o
);

    localparam int            CW   = $clog2(CYCLES_PER_COL);
    localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_COL - 1);

    logic [CW-1:0]    cyc_q, cyc_d;
    logic [1:0]       col_q, col_d;
    logic [3:0]       cols_q, cols_d;
    logic [3:0]       sync1_q, sync2_q;
    logic [1:0]       acc_cnt_q, acc_cnt_d;
    logic [KEY_W-1:0] acc_code_q, acc_code_d;
    logic             done_q, done_d;
    frame_res_e       res_q, res_d;
    logic [KEY_W-1:0] code_q, code_d;

    logic             sample_s;
    logic [3:0]       low_s;
    logic [2:0]       pop_s;
    logic [2:0]       sum_s;
    logic [1:0]       cnt_new_s;
    logic [KEY_W-1:0] code_new_s;

    // Next-state logic: column advance and running frame accumulation at each sample point.
    always_comb begin
        sample_s   = (cyc_q == LAST);
        low_s      = ~sync2_q;
        pop_s      = count_low(low_s);
        // Column 0 starts a fresh frame, so the accumulator is ignored there.
        sum_s      = ((col_q == 2'd0) ? 3'd0 : {1'b0, acc_cnt_q}) + pop_s;
        cnt_new_s  = (sum_s >= 3'd2) ? 2'd2 : sum_s[1:0];
        code_new_s = (pop_s != 3'd0) ? {low_row_index(low_s), col_q}
                   : ((col_q == 2'd0) ? {KEY_W{1'b0}} : acc_code_q);

        cyc_d      = cyc_q + {{(CW-1){1'b0}}, 1'b1};
        col_d      = col_q;
        cols_d     = cols_q;
        acc_cnt_d  = acc_cnt_q;
        acc_code_d = acc_code_q;
        done_d     = 1'b0;
        res_d      = res_q;
        code_d     = code_q;
        if (sample_s) begin
            cyc_d      = {CW{1'b0}};
            col_d      = col_q + 2'd1;
            cols_d     = COL_IDLE_MASK & ~(4'b0001 << col_d);
            acc_cnt_d  = cnt_new_s;
            acc_code_d = code_new_s;
            if (col_q == 2'd3) begin
                done_d = 1'b1;
                code_d = code_new_s;
                case (cnt_new_s)
                    2'd0:    res_d = FR_NONE;
                    2'd1:    res_d = FR_SINGLE;
                    default: res_d = FR_MULTI;
                endcase
            end else begin
                done_d = 1'b0;
            end
        end else begin
            done_d = 1'b0;
        end
    end

    // State registers and the two-flop row synchronizer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cyc_q      <= {CW{1'b0}};
            col_q      <= 2'd0;
            cols_q     <= COL0_STROBE;
            sync1_q    <= 4'hF;
            sync2_q    <= 4'hF;
            acc_cnt_q  <= 2'd0;
            acc_code_q <= {KEY_W{1'b0}};
            done_q     <= 1'b0;
            res_q      <= FR_NONE;
            code_q     <= {KEY_W{1'b0}};
        end else begin
            cyc_q      <= cyc_d;
            col_q      <= col_d;
            cols_q     <= cols_d;
            sync1_q    <= rows_i;
            sync2_q    <= sync1_q;
            acc_cnt_q  <= acc_cnt_d;
            acc_code_q <= acc_code_d;
            done_q     <= done_d;
            res_q      <= res_d;
            code_q     <= code_d;
        end
    end

    assign cols_o         = cols_q;
    assign frame_done_o   = done_q;
    assign frame_result_o = res_q;
    assign frame_code_o   = code_q;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner top: debounces scan-frame results into an accepted key code
// with a one-cycle valid pulse and a held level.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int CYCLES_PER_COL  = 50_000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [3:0]       ROWS,
    output logic [3:0]       COLS,
    output logic [KEY_W-1:0] KEY_CODE,
    output logic             KEY_VALID,
    output logic             KEY_HELD
);

    localparam int               CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CNT_W-1:0] DF_C  = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    logic             frame_done_s;
    frame_res_e       frame_result_s;
    logic [KEY_W-1:0] frame_code_s;

    kp_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [KEY_W-1:0] cand_q;
    logic [KEY_W-1:0] key_code_q;
    logic             key_valid_q;
    logic             key_held_q;
    logic [CNT_W-1:0] cnt_inc_s;

    keypad_col_scanner #(
        .CYCLES_PER_COL(CYCLES_PER_COL)
    ) u_scan (
        .clk_i         (CLK),
        .rst_i         (RST),
        .rows_i        (ROWS),
        .cols_o        (COLS),
        .frame_done_o  (frame_done_s),
        .frame_result_o(frame_result_s),
        .frame_code_o  (frame_code_s)
    );

    assign cnt_inc_s = cnt_q + ONE_C;

    // Debounce FSM, stepped once per evaluated frame; outputs are registered here.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            cand_q      <= {KEY_W{1'b0}};
            key_code_q  <= {KEY_W{1'b0}};
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (frame_done_s) begin
                case (state_q)
                    ST_IDLE: begin
                        if (frame_result_s == FR_SINGLE) begin
                            cand_q <= frame_code_s;
                            if (ONE_C == DF_C) begin
                                key_code_q  <= frame_code_s;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                                state_q     <= ST_HELD;
                                cnt_q       <= {CNT_W{1'b0}};
                            end else begin
                                state_q <= ST_DEBOUNCE;
                                cnt_q   <= ONE_C;
                            end
                        end else begin
                            cnt_q <= {CNT_W{1'b0}};
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (frame_result_s == FR_SINGLE && frame_code_s == cand_q) begin
                            if (cnt_inc_s == DF_C) begin
                                key_code_q  <= cand_q;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                                state_q     <= ST_HELD;
                                cnt_q       <= {CNT_W{1'b0}};
                            end else begin
                                cnt_q <= cnt_inc_s;
                            end
                        end else begin
                            state_q <= ST_IDLE;
                            cnt_q   <= {CNT_W{1'b0}};
                        end
                    end
                    ST_HELD: begin
                        if (frame_result_s == FR_NONE) begin
                            if (cnt_inc_s == DF_C) begin
                                key_held_q <= 1'b0;
                                state_q    <= ST_IDLE;
                                cnt_q      <= {CNT_W{1'b0}};
                            end else begin
                                cnt_q <= cnt_inc_s;
                            end
                        end else begin
                            cnt_q <= {CNT_W{1'b0}};
                        end
                    end
                    default: begin
                        state_q    <= ST_IDLE;
                        cnt_q      <= {CNT_W{1'b0}};
                        key_held_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign KEY_CODE  = key_code_q;
    assign KEY_VALID = key_valid_q;
    assign KEY_HELD  = key_held_q;

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Input-side counterpart of the multiplexed 7-segment display driver: drives a 4x4 matrix keypad's columns with a rotating active-low strobe and reads the rows back.
- Debounces and reports a single key as a 4-bit code with a one-cycle valid pulse and a held level.
- Its output feeds the selection logic (BOTON_SEL-style) of the image-processing top level.

Parameters:
- CYCLES_PER_COL, 50_000, CLK cycles each column is strobed (1 ms at 50 MHz); must be >= 4.
- DEBOUNCE_FRAMES, 4, consecutive identical full scan frames required to accept a press or a release; must be >= 1.

Ports:
- CLK  input  1  system clock, 50 MHz
- RST  input  1  reset; asynchronous, active-high
- ROWS  input  4  keypad rows; pulled up; active-low when a key connects the row to the strobed column
- COLS  output  4  column strobe, active-low, exactly one bit low at all times
- KEY_CODE  output  4  last accepted key, code = row*4 + col
- KEY_VALID  output  1  one-cycle pulse when a new key is accepted
- KEY_HELD  output  1  high while the accepted key is considered pressed

Behaviour:
- Reset (async, RST=1): COLS=4'b1110 (column 0), column counter=0, cycle counter=0, sync flops=4'hF, KEY_CODE=0, KEY_VALID=0, KEY_HELD=0, FSM=IDLE, debounce count=0.
- ROWS passes through a 2-flop synchronizer, reset value 4'hF. All decisions use the synchronized value.
- Cycle counter runs 0..CYCLES_PER_COL-1 and wraps.
- On count==CYCLES_PER_COL-1:
  - Sample the synchronized rows for the current column.
  - Advance the column 0->1->2->3->0. COLS changes on the next edge.
- Column c drives COLS bit c low; all other bits stay high.
- A frame is the four samples of columns 0..3. On the column-3 sample the frame is complete and its result is evaluated on the following cycle:
  - No low row bit in any column -> NONE.
  - Exactly one low bit in the whole frame -> SINGLE(k).
  - Two or more low bits -> MULTI, treated as NONE for press qualification and as not-released in HELD.
- FSM, updated only at frame evaluation:
  - IDLE: SINGLE(k) -> DEBOUNCE, cand=k, cnt=1. Anything else stays in IDLE. If DEBOUNCE_FRAMES==1, go directly to the accept action.
  - DEBOUNCE: SINGLE(cand) -> cnt+1. When cnt reaches DEBOUNCE_FRAMES: KEY_CODE<=cand, KEY_VALID=1 for exactly one cycle, KEY_HELD<=1, go to HELD, cnt=0. Any other result -> IDLE, cnt=0.
  - HELD: NONE -> cnt+1. SINGLE of any key or MULTI -> cnt=0; a second key is never reported. When cnt reaches DEBOUNCE_FRAMES: KEY_HELD<=0, go to IDLE. KEY_CODE is held unchanged.
- KEY_VALID latency: asserted one cycle after the sample edge of the column-3 sample that completes the DEBOUNCE_FRAMES-th matching frame.
- Counter widths: the cycle counter uses clog2(CYCLES_PER_COL) bits; the debounce counter uses clog2(DEBOUNCE_FRAMES+1) bits. Neither counter overflows, because both saturate at their compare value.
- Reset mid-operation: all state returns to reset values immediately. No KEY_VALID pulse is generated on or after reset release until a fresh full debounce completes.
- A key pressed at reset release is accepted normally after DEBOUNCE_FRAMES frames.

Decomposition:
- Shared package (keypad_pkg):
  - FSM state encoding IDLE/DEBOUNCE/HELD.
  - Frame result encoding NONE/SINGLE/MULTI.
  - KEY_W=4.
  - COL_IDLE_MASK=4'hF.
  - Column 0 strobe constant 4'b1110.
- One sub-module, keypad_col_scanner: cycle counter, column rotation, synchronizer, per-frame sample collection and NONE/SINGLE/MULTI + code evaluation. It emits frame_done (1-cycle) with frame_result and frame_code.
- The top level holds the debounce FSM and the output registers.

Test Plan (CYCLES_PER_COL=8, DEBOUNCE_FRAMES=3; one frame = 32 cycles):
- Reset hold and rotation: release RST, ROWS=4'hF -> COLS steps 1110,1101,1011,0111 every 8 cycles; KEY_VALID and KEY_HELD stay 0 for 10 frames.
- Clean press: model key row 2 / col 1 (ROWS[2] low while COLS[1] low) continuously -> exactly one KEY_VALID pulse with KEY_CODE=9 after the 3rd full frame; KEY_HELD=1.
- Release: after the press is accepted, remove the key -> KEY_HELD drops after 3 NONE frames; no KEY_VALID pulse; KEY_CODE stays 9.
- Bounce rejection: key 5 present in frame 1, absent in frame 2, present in frames 3-4 -> no KEY_VALID. Present in frames 3-5 -> one pulse, KEY_CODE=5.
- Multi-key: keys 0 and 15 held together -> no KEY_VALID. While key 3 is HELD, add key 7 -> no new pulse, KEY_HELD stays 1.
- Async reset mid-debounce: assert RST during frame 2 of a press on key 12 -> outputs reset at once (COLS=1110). After release with key 12 still held -> KEY_VALID only after 3 fresh frames.
